instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, setting the number of 16-bit program buffer entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1 bit; when low, all state and outputs SHALL hold.
REQ-005 The block SHALL have port wr_valid, input, 1 bit, program byte strobe.
REQ-006 The block SHALL have port wr_byte, input, 8 bits, program byte, high byte first.
REQ-007 The block SHALL have port wr_ready, output, 1 bit, byte acceptance, combinational.
REQ-008 The block SHALL have port prog_clr, input, 1 bit, which empties the program buffer.
REQ-009 The block SHALL have port run_start, input, 1 bit, which requests program execution.
REQ-010 The block SHALL have port run_abort, input, 1 bit, which terminates execution.
REQ-011 The block SHALL have port issue_valid, output, 1 bit, indicating an instruction is presented to the compute unit.
REQ-012 The block SHALL have port issue_instr, output, 16 bits, the instruction: opcode [15:12], target [11:8], src0 [7:4], src1 [3:0].
REQ-013 The block SHALL have port issue_ready, input, 1 bit, the compute unit's acceptance signal.
REQ-014 The block SHALL have port busy, output, 1 bit, high in states RUN and DONE.
REQ-015 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-016 The block SHALL have port err, output, 1 bit, a sticky error flag.
REQ-017 The block SHALL have port prog_len, output, $clog2(DEPTH)+1 bits, the number of complete stored entries.

Function
REQ-018 The state machine SHALL have states IDLE, RUN and DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 wr_ready SHALL be 1 only in IDLE with prog_len < DEPTH and prog_clr low.
REQ-020 Byte load:
- The first accepted byte (wr_valid&&wr_ready) SHALL go to a hold register and set a phase bit.
- The second accepted byte SHALL write {hold, wr_byte} at index prog_len, increment prog_len and clear the phase bit.
REQ-021 When full (prog_len==DEPTH), wr_ready SHALL be 0, bytes SHALL be dropped and no state SHALL change.
REQ-022 prog_clr in IDLE SHALL set prog_len to 0, clear the phase bit and clear err; prog_clr in RUN or DONE SHALL be ignored.
REQ-023 IDLE priority SHALL be prog_clr > accepted byte > run_start; a run_start in the same cycle as a higher-priority event SHALL be ignored.
REQ-024 run_start with prog_len==0 or the phase bit set SHALL NOT leave IDLE and SHALL set err.
REQ-025 Valid run_start sampled at edge N:
- The state SHALL be RUN from edge N.
- The read pointer SHALL be 0.
- issue_valid=1 and issue_instr=entry[0] SHALL be registered outputs visible in cycle N+1.
REQ-026 While issue_valid=1 and issue_ready=0, issue_instr SHALL stay stable.
REQ-027 A transfer SHALL occur at each edge with issue_valid&&issue_ready.
REQ-028 After a transfer, the next entry SHALL be presented in the following cycle, so back-to-back issue at one per cycle is possible.
REQ-029 An entry with opcode 4'b1111 (HALT) SHALL NOT be issued: when the read pointer reaches it, issue_valid SHALL be 0 and the state SHALL go to DONE.
REQ-030 A transfer of the last entry (index prog_len-1) SHALL go to DONE with issue_valid=0 in the next cycle.
REQ-031 done SHALL be 1 exactly in the DONE cycle.
REQ-032 run_abort in RUN SHALL go to IDLE at the next edge:
- issue_valid SHALL be 0.
- No done pulse SHALL be produced.
- The program SHALL be retained.
- It SHALL take priority over a simultaneous transfer, which is still counted as accepted by the compute unit.
REQ-033 wr_valid and run_start SHALL be ignored outside IDLE.
REQ-034 The program buffer SHALL be retained across runs, so repeated run_start re-executes it.

Reset
REQ-035 On rst_n=0 at a clock edge (regardless of ena), the block SHALL set the state to IDLE and set to 0: issue_valid, issue_instr, done, err, busy, prog_len, the phase bit and the read pointer.
REQ-036 Reset SHALL NOT clear buffer contents, but the contents SHALL be unreachable until rewritten.
REQ-037 Reset mid-RUN SHALL drop issue_valid in the next cycle without a done pulse.

Configuration
REQ-038 Macro SEQ_LOOP_EN defined SHALL add input loop_cnt, 4 bits, sampled at run_start.
- The program SHALL execute loop_cnt+1 times.
- After the last entry of a non-final pass, the read pointer SHALL return to 0 with no idle cycle.
- HALT, abort and done SHALL apply to the whole run.
REQ-039 Macro SEQ_LOOP_EN undefined SHALL mean no loop_cnt port and a single pass per run_start.

Verification
REQ-040 Scenario 1:
- Stimulus: write bytes 0x13,0x05 / 0x14,0x07 / 0x25,0x34, then run_start with issue_ready=1.
- Response: issue_instr 0x1305, 0x1407, 0x2534 on three consecutive cycles starting N+1, then a done pulse one cycle after the last, and busy low next.
REQ-041 Scenario 2:
- Stimulus: same program with issue_ready low for 3 cycles on the second entry.
- Response: 0x1407 held 3 cycles, then completion shifted by 3 cycles.
REQ-042 Scenario 3:
- Stimulus: write DEPTH entries, then one extra byte.
- Response: wr_ready=0, the extra byte dropped, prog_len=DEPTH.
- Then run_start with only 1 byte after prog_clr gives err=1 and state IDLE.
REQ-043 Scenario 4:
- Stimulus: program 0x1301, 0xF000, 0x2301.
- Response: only 0x1301 issued, then a done pulse.
REQ-044 Scenario 5:
- Stimulus: run_abort during issue of the second of 3 entries.
- Response: issue_valid=0 next cycle and no done.
- Stimulus: rerun.
- Response: starts from 0x1305.
REQ-045 Scenario 6:
- Stimulus: with SEQ_LOOP_EN, loop_cnt=2 on a 2-entry program.
- Response: 6 transfers back-to-back, then one done pulse.
- Also check: with ena=0 for 2 cycles mid-run, all outputs hold.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program-buffer instruction sequencer: loads 16-bit instructions byte-wise, then issues them
// in order over a valid/ready handshake. Optional build macro SEQ_LOOP_EN adds a loop_cnt repeat port.
module instr_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_byte,
    output logic                     wr_ready,
    input  logic                     prog_clr,
    input  logic                     run_start,
    input  logic                     run_abort,
    output logic                     issue_valid,
    output logic [15:0]              issue_instr,
    input  logic                     issue_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   prog_len
`ifdef SEQ_LOOP_EN
    ,
    input  logic [3:0]               loop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:12] == 4'b1111);
    endfunction

    logic [15:0]   mem [DEPTH];

    state_t        state_r, state_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [LW-1:0] prog_len_r, prog_len_s;
    logic          phase_r, phase_s;
    logic [7:0]    hold_r, hold_s;
    logic          err_r, err_s;
    logic          issue_valid_r, issue_valid_s;
    logic [15:0]   issue_instr_r, issue_instr_s;
    logic          done_r, done_s;
    logic          busy_r, busy_s;
    logic          wr_en_s;

    logic          accept_s, xfer_s, start_ok_s, last_s, last_pass_s, wrap_s;
    logic [AW-1:0] next_ptr_s;
    logic [15:0]   first_instr_s, next_instr_s;

`ifdef SEQ_LOOP_EN
    logic [3:0]    loops_r, loops_s;
    assign last_pass_s = (loops_r == 4'd0);
`else
    assign last_pass_s = 1'b1;
`endif

    assign wr_ready      = (state_r == IDLE) && (prog_len_r < LW'(DEPTH)) && !prog_clr;
    assign accept_s      = wr_valid && wr_ready;
    assign xfer_s        = issue_valid_r && issue_ready;
    assign start_ok_s    = run_start && (prog_len_r != LW'(0)) && !phase_r;
    assign last_s        = ({1'b0, ptr_r} == (prog_len_r - LW'(1)));
    assign wrap_s        = last_s && !last_pass_s;
    assign next_ptr_s    = wrap_s ? AW'(0) : AW'(ptr_r + AW'(1));
    assign first_instr_s = mem[AW'(0)];
    assign next_instr_s  = mem[next_ptr_s];

    // State register; synchronous reset wins over ena
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (ena) begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (prog_clr || accept_s) begin
                    state_s = IDLE;
                end else if (start_ok_s) begin
                    state_s = is_halt(first_instr_s) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (run_abort) begin
                    state_s = IDLE;
                end else if (xfer_s) begin
                    if ((last_s && last_pass_s) || is_halt(next_instr_s)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        ptr_s         = ptr_r;
        prog_len_s    = prog_len_r;
        phase_s       = phase_r;
        hold_s        = hold_r;
        err_s         = err_r;
        issue_valid_s = issue_valid_r;
        issue_instr_s = issue_instr_r;
        done_s        = (state_s == DONE);
        busy_s        = (state_s != IDLE);
        wr_en_s       = 1'b0;
`ifdef SEQ_LOOP_EN
        loops_s       = loops_r;
`endif
        case (state_r)
            IDLE: begin
                if (prog_clr) begin
                    prog_len_s = LW'(0);
                    phase_s    = 1'b0;
                    err_s      = 1'b0;
                end else if (accept_s) begin
                    if (!phase_r) begin
                        hold_s  = wr_byte;
                        phase_s = 1'b1;
                    end else begin
                        wr_en_s    = 1'b1;
                        prog_len_s = prog_len_r + LW'(1);
                        phase_s    = 1'b0;
                    end
                end else if (run_start) begin
                    if (start_ok_s) begin
                        ptr_s         = AW'(0);
                        issue_valid_s = !is_halt(first_instr_s);
                        issue_instr_s = first_instr_s;
`ifdef SEQ_LOOP_EN
                        loops_s       = loop_cnt;
`endif
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    issue_valid_s = 1'b0;
                end
            end
            RUN: begin
                if (run_abort) begin
                    issue_valid_s = 1'b0;
                end else if (xfer_s) begin
                    if (state_s == RUN) begin
                        ptr_s         = next_ptr_s;
                        issue_instr_s = next_instr_s;
`ifdef SEQ_LOOP_EN
                        if (wrap_s) begin
                            loops_s = loops_r - 4'd1;
                        end else begin
                            loops_s = loops_r;
                        end
`endif
                    end else begin
                        issue_valid_s = 1'b0;
                    end
                end else begin
                    issue_valid_s = issue_valid_r;
                end
            end
            DONE: begin
                issue_valid_s = 1'b0;
            end
            default: begin
                issue_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r         <= AW'(0);
            prog_len_r    <= LW'(0);
            phase_r       <= 1'b0;
            hold_r        <= 8'd0;
            err_r         <= 1'b0;
            issue_valid_r <= 1'b0;
            issue_instr_r <= 16'd0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
`ifdef SEQ_LOOP_EN
            loops_r       <= 4'd0;
`endif
        end else if (ena) begin
            ptr_r         <= ptr_s;
            prog_len_r    <= prog_len_s;
            phase_r       <= phase_s;
            hold_r        <= hold_s;
            err_r         <= err_s;
            issue_valid_r <= issue_valid_s;
            issue_instr_r <= issue_instr_s;
            done_r        <= done_s;
            busy_r        <= busy_s;
`ifdef SEQ_LOOP_EN
            loops_r       <= loops_s;
`endif
        end
    end

    // Program buffer is not reset; prog_len gates what is reachable
    always_ff @(posedge clk) begin
        if (rst_n && ena && wr_en_s) begin
            mem[prog_len_r[AW-1:0]] <= {hold_r, wr_byte};
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_instr = issue_instr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign prog_len    = prog_len_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; issued instructions are checked against a scoreboard queue.
module tb_instr_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_byte = 8'd0;
    logic        wr_ready;
    logic        prog_clr = 1'b0;
    logic        run_start = 1'b0;
    logic        run_abort = 1'b0;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic        issue_ready = 1'b0;
    logic        busy, done, err;
    logic [3:0]  prog_len;
`ifdef SEQ_LOOP_EN
    logic [3:0]  loop_cnt = 4'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_byte(wr_byte), .wr_ready(wr_ready),
        .prog_clr(prog_clr), .run_start(run_start), .run_abort(run_abort),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .busy(busy), .done(done), .err(err), .prog_len(prog_len)
`ifdef SEQ_LOOP_EN
        , .loop_cnt(loop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_valid = 1'b1;
        wr_byte  = w[15:8];
        step();
        wr_byte  = w[7:0];
        step();
        wr_valid = 1'b0;
    endtask

    task automatic clear_prog();
        prog_clr = 1'b1;
        step();
        prog_clr = 1'b0;
    endtask

    task automatic start_run();
        run_start = 1'b1;
        step();
        run_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int seen = 0;
        for (int i = 0; i < max_cycles && seen == 0; i++) begin
            if (done === 1'b1) seen = 1;
            else step();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Transfer monitor: a transfer happens at the coming edge when valid&&ready with ena and no reset
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ena === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("xfer_unexpected", {16'd0, issue_instr}, 32'hDEAD);
            else chk("xfer", {16'd0, issue_instr}, {16'd0, exp_q.pop_front()});
        end
    end

    initial begin
        // Reset
        step(2);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_instr", 32'(issue_instr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_len", 32'(prog_len), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);

        // Scenario 1: three entries back-to-back
        write_word(16'h1305);
        write_word(16'h1407);
        write_word(16'h2534);
        chk("s1_len", 32'(prog_len), 32'd3);
        exp_q.push_back(16'h1305); exp_q.push_back(16'h1407); exp_q.push_back(16'h2534);
        issue_ready = 1'b1;
        start_run();
        chk("s1_v0", 32'(issue_valid), 32'd1);
        chk("s1_i0", 32'(issue_instr), 32'h1305);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_wr_ready_run", 32'(wr_ready), 32'd0);
        step();
        chk("s1_i1", 32'(issue_instr), 32'h1407);
        step();
        chk("s1_i2", 32'(issue_instr), 32'h2534);
        step();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_done_valid", 32'(issue_valid), 32'd0);
        chk("s1_done_busy", 32'(busy), 32'd1);
        step();
        chk("s1_done_end", 32'(done), 32'd0);
        chk("s1_busy_end", 32'(busy), 32'd0);

        // Scenario 2: stall 3 cycles on the second entry
        exp_q.push_back(16'h1305); exp_q.push_back(16'h1407); exp_q.push_back(16'h2534);
        start_run();
        chk("s2_i0", 32'(issue_instr), 32'h1305);
        step();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_v", 32'(issue_valid), 32'd1);
            chk("s2_hold_i", 32'(issue_instr), 32'h1407);
            step();
        end
        issue_ready = 1'b1;
        chk("s2_i1_go", 32'(issue_instr), 32'h1407);
        step();
        chk("s2_i2", 32'(issue_instr), 32'h2534);
        step();
        chk("s2_done", 32'(done), 32'd1);
        step();

        // ena low for 2 cycles mid-run holds everything
        exp_q.push_back(16'h1305); exp_q.push_back(16'h1407); exp_q.push_back(16'h2534);
        start_run();
        step();
        ena = 1'b0;
        step();
        chk("ena_hold_i", 32'(issue_instr), 32'h1407);
        chk("ena_hold_v", 32'(issue_valid), 32'd1);
        step();
        chk("ena_hold_i2", 32'(issue_instr), 32'h1407);
        chk("ena_hold_busy", 32'(busy), 32'd1);
        ena = 1'b1;
        step();
        chk("ena_resume", 32'(issue_instr), 32'h2534);
        step();
        chk("ena_done", 32'(done), 32'd1);
        step();

        // Scenario 5: abort on the second entry (that transfer still counts), then rerun
        exp_q.push_back(16'h1305); exp_q.push_back(16'h1407);
        start_run();
        step();
        run_abort = 1'b1;
        step();
        run_abort = 1'b0;
        chk("s5_abort_valid", 32'(issue_valid), 32'd0);
        chk("s5_abort_busy", 32'(busy), 32'd0);
        chk("s5_abort_done", 32'(done), 32'd0);
        step();
        chk("s5_abort_done2", 32'(done), 32'd0);
        chk("s5_len_kept", 32'(prog_len), 32'd3);
        exp_q.push_back(16'h1305); exp_q.push_back(16'h1407); exp_q.push_back(16'h2534);
        start_run();
        chk("s5_rerun_i0", 32'(issue_instr), 32'h1305);
        wait_done("s5_rerun_done", 10);
        step();

        // Scenario 4: HALT in the middle
        clear_prog();
        write_word(16'h1301);
        write_word(16'hF000);
        write_word(16'h2301);
        exp_q.push_back(16'h1301);
        start_run();
        chk("s4_i0", 32'(issue_instr), 32'h1301);
        step();
        chk("s4_halt_valid", 32'(issue_valid), 32'd0);
        chk("s4_halt_done", 32'(done), 32'd1);
        step();
        chk("s4_idle_busy", 32'(busy), 32'd0);

        // Scenario 3: fill, drop extra byte, run all, then error cases
        clear_prog();
        for (int i = 0; i < DEPTH; i++) write_word(16'h1000 + 16'(i * 16'h0111));
        chk("s3_full_ready", 32'(wr_ready), 32'd0);
        chk("s3_full_len", 32'(prog_len), 32'(DEPTH));
        wr_valid = 1'b1; wr_byte = 8'hEE;
        step();
        wr_valid = 1'b0;
        chk("s3_drop_len", 32'(prog_len), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(16'h1000 + 16'(i * 16'h0111));
        start_run();
        wait_done("s3_full_done", DEPTH + 4);
        step();
        clear_prog();
        chk("s3_clr_len", 32'(prog_len), 32'd0);
        wr_valid = 1'b1; wr_byte = 8'h13;
        step();
        wr_valid = 1'b0;
        start_run();
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_err_busy", 32'(busy), 32'd0);
        chk("s3_err_valid", 32'(issue_valid), 32'd0);
        clear_prog();
        chk("s3_err_clr", 32'(err), 32'd0);
        start_run();
        chk("s3_err_empty", 32'(err), 32'd1);
        clear_prog();

`ifdef SEQ_LOOP_EN
        // Scenario 6: 2-entry program executed 3 times back-to-back
        write_word(16'h1301);
        write_word(16'h2302);
        loop_cnt = 4'd2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h1301); exp_q.push_back(16'h2302);
        end
        start_run();
        loop_cnt = 4'd0;
        for (int i = 0; i < 6; i++) begin
            chk("s6_loop_v", 32'(issue_valid), 32'd1);
            chk("s6_loop_i", 32'(issue_instr), (i % 2 == 0) ? 32'h1301 : 32'h2302);
            step();
        end
        chk("s6_done", 32'(done), 32'd1);
        step();
        chk("s6_done_once", 32'(done), 32'd0);
        clear_prog();
`endif

        // Reset mid-run drops issue_valid with no done pulse
        write_word(16'h1305);
        write_word(16'h1407);
        issue_ready = 1'b0;
        start_run();
        chk("mr_valid_pre", 32'(issue_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valid", 32'(issue_valid), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_len", 32'(prog_len), 32'd0);
        step();
        chk("mr_done2", 32'(done), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
